// File: rtl/crc_pkg.sv
// crc_pkg: shared constants, state and owner types for the CRC arbitration engine
package crc_pkg;
    localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;
    typedef enum logic [1:0] {IDLE, CPU_RUN, SEAL_OWN, SEAL_RUN} state_e;
    typedef enum logic {OWN_CPU, OWN_SEAL} owner_e;
    function automatic owner_e owner_of(state_e s);
        return (s == SEAL_OWN || s == SEAL_RUN) ? OWN_SEAL : OWN_CPU;
    endfunction
endpackage

// File: rtl/crc32_step.sv
// crc32_step: folds BITS_PER_CYCLE LSB-first data bits into a reflected CRC-32
module crc32_step
    import crc_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic [31:0]               crc,
    input  logic [BITS_PER_CYCLE-1:0] data,
    output logic [31:0]               next_crc
);
    always_comb begin
        next_crc = crc;
        for (int i = 0; i < BITS_PER_CYCLE; i++)
            next_crc = (next_crc >> 1) ^ ((next_crc[0] ^ data[i]) ? CRC32_POLY : 32'h0);
    end
endmodule

// File: rtl/crc_arb_engine.sv
// crc_arb_engine: one bit-serial CRC-32 datapath shared by the seal sequencer (priority) and the CPU port
module crc_arb_engine
    import crc_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_init,
    input  logic        cpu_valid,
    input  logic [7:0]  cpu_data,
    output logic        cpu_ready,
    output logic        cpu_busy,
    output logic [31:0] cpu_crc,
    input  logic        seal_req,
    output logic        seal_gnt,
    input  logic        seal_init,
    input  logic        seal_valid,
    input  logic [7:0]  seal_data,
    output logic        seal_ready,
    output logic [31:0] seal_crc
);
    localparam int CYCLES = 8 / BITS_PER_CYCLE;
    state_e      state, state_nx;
    logic [31:0] cpu_acc, seal_acc, step_out;
    logic [7:0]  sh;
    logic [2:0]  cnt;
    logic        init_pend, running, last, cpu_take, seal_take;
    assign seal_gnt   = owner_of(state) == OWN_SEAL;
    assign cpu_ready  = state == IDLE && !seal_req;
    assign seal_ready = state == SEAL_OWN;
    assign cpu_busy   = state != IDLE;
    assign cpu_crc    = cpu_acc ^ CRC32_XOROUT;
    assign seal_crc   = seal_acc ^ CRC32_XOROUT;
    assign running    = state == CPU_RUN || state == SEAL_RUN;
    assign last       = running && cnt == 3'(CYCLES - 1);
    assign cpu_take   = cpu_valid && cpu_ready;
    assign seal_take  = seal_valid && seal_ready;
    crc32_step #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
        .crc      (seal_gnt ? seal_acc : cpu_acc),
        .data     (sh[BITS_PER_CYCLE-1:0]),
        .next_crc (step_out)
    );
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = seal_req ? SEAL_OWN : cpu_take ? CPU_RUN : IDLE;
            SEAL_OWN: state_nx = !seal_req ? IDLE : seal_take ? SEAL_RUN : SEAL_OWN;
            default:  state_nx = !last ? state : seal_req ? SEAL_OWN : IDLE;
        endcase
    end
    // A cpu_init seen mid-byte is parked and overrides that byte's result at completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            sh        <= 8'd0;
            init_pend <= 1'b0;
            cpu_acc   <= CRC32_INIT;
            seal_acc  <= CRC32_INIT;
        end else begin
            state     <= state_nx;
            cnt       <= (running && !last) ? cnt + 3'd1 : 3'd0;
            sh        <= cpu_take ? cpu_data : seal_take ? seal_data : running ? sh >> BITS_PER_CYCLE : sh;
            init_pend <= state == CPU_RUN && !last && (init_pend || cpu_init);
            cpu_acc   <= state == CPU_RUN ? ((last && (init_pend || cpu_init)) ? CRC32_INIT : step_out)
                                          : (cpu_init ? CRC32_INIT : cpu_acc);
            seal_acc  <= state == SEAL_RUN ? step_out : (seal_gnt && seal_init) ? CRC32_INIT : seal_acc;
        end
    end
endmodule

// File: tb/tb_crc_arb_engine.sv
// tb_crc_arb_engine: scoreboard bench with a byte-level CRC-32 reference model
module tb_crc_arb_engine;
    logic        clk = 0, rst_n = 0;
    logic        cpu_init = 0, cpu_valid = 0, seal_req = 0, seal_init = 0, seal_valid = 0;
    logic [7:0]  cpu_data = 0, seal_data = 0;
    logic        cpu_ready, cpu_busy, seal_gnt, seal_ready;
    logic [31:0] cpu_crc, seal_crc;
    string       nm_q[$];
    int          kd_q[$];
    logic [31:0] ex_q[$];
    int          n_checks = 0, n_fail = 0;
    logic [31:0] m_cpu = 32'hFFFFFFFF, m_seal = 32'hFFFFFFFF;
    logic [7:0]  s9 [0:8] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    string       mon_n;
    int          mon_k;
    logic [31:0] mon_e;

    crc_arb_engine dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_init(cpu_init), .cpu_valid(cpu_valid), .cpu_data(cpu_data),
        .cpu_ready(cpu_ready), .cpu_busy(cpu_busy), .cpu_crc(cpu_crc),
        .seal_req(seal_req), .seal_gnt(seal_gnt), .seal_init(seal_init),
        .seal_valid(seal_valid), .seal_data(seal_data),
        .seal_ready(seal_ready), .seal_crc(seal_crc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    function automatic logic [31:0] status();
        return {28'h0, seal_gnt, cpu_busy, cpu_ready, seal_ready};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic expect_item(input string name, input int kind, input logic [31:0] exp);
        nm_q.push_back(name);
        kd_q.push_back(kind);
        ex_q.push_back(exp);
    endtask

    // Monitor: compares whenever the engine is quiescent (no byte in flight).
    always @(negedge clk) begin
        if (rst_n && nm_q.size() != 0 && (!cpu_busy || seal_ready)) begin
            mon_n = nm_q.pop_front();
            mon_k = kd_q.pop_front();
            mon_e = ex_q.pop_front();
            check(mon_n, mon_k == 0 ? cpu_crc : mon_k == 1 ? seal_crc : status(), mon_e);
        end
    end

    task automatic sync();
        int t = 0;
        while (nm_q.size() != 0 && t < 200) begin @(negedge clk); t++; end
        if (nm_q.size() != 0) begin
            check("sync_timeout", 32'(nm_q.size()), 0);
            nm_q.delete(); kd_q.delete(); ex_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic send_cpu(input logic [7:0] b);
        int t = 0;
        cpu_valid = 1; cpu_data = b; #1;
        while (!cpu_ready && t < 200) begin @(negedge clk); t++; end
        if (!cpu_ready) check("cpu_accept_timeout", {31'h0, cpu_ready}, 1);
        @(posedge clk); @(negedge clk);
        cpu_valid = 0;
        m_cpu = crc_upd(m_cpu, b);
    endtask

    task automatic send_seal(input logic [7:0] b, input logic init);
        int t = 0;
        seal_valid = 1; seal_data = b; seal_init = init; #1;
        while (!seal_ready && t < 200) begin @(negedge clk); t++; end
        if (!seal_ready) check("seal_accept_timeout", {31'h0, seal_ready}, 1);
        @(posedge clk); @(negedge clk);
        seal_valid = 0; seal_init = 0;
        if (init) m_seal = 32'hFFFFFFFF;
        m_seal = crc_upd(m_seal, b);
    endtask

    task automatic pulse_cpu_init();
        cpu_init = 1;
        @(posedge clk); @(negedge clk);
        cpu_init = 0;
        m_cpu = 32'hFFFFFFFF;
    endtask

    task automatic grant();
        int t = 0;
        seal_req = 1;
        @(negedge clk);
        while (!seal_gnt && t < 200) begin @(negedge clk); t++; end
        if (!seal_gnt) check("grant_timeout", {31'h0, seal_gnt}, 1);
    endtask

    task automatic release_seal();
        seal_req = 0;
        @(negedge clk); @(negedge clk);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        expect_item("rst_cpu_crc", 0, 0);
        expect_item("rst_seal_crc", 1, 0);
        expect_item("rst_status", 2, 4'b0010);
        sync();

        // CPU alone, with byte latency
        pulse_cpu_init();
        send_cpu(s9[0]);
        t = 0;
        while (cpu_busy && t < 20) begin t++; @(negedge clk); end
        check("cpu_byte_latency", t, 4);
        for (int i = 1; i < 9; i++) send_cpu(s9[i]);
        expect_item("cpu_model_123456789", 0, ~m_cpu);
        expect_item("cpu_check_value", 0, 32'hCBF43926);
        expect_item("cpu_idle_status", 2, 4'b0010);
        sync();

        // Seal alone
        seal_req = 1; #1;
        check("cpu_ready_masked_by_req", {31'h0, cpu_ready}, 0);
        @(negedge clk);
        check("gnt_next_cycle", {31'h0, seal_gnt}, 1);
        send_seal(8'h00, 1);
        for (int i = 0; i < 3; i++) send_seal(8'h00, 0);
        expect_item("seal_zero4_value", 1, 32'h2144DF1C);
        expect_item("seal_zero4_model", 1, ~m_seal);
        sync();
        seal_req = 0;
        @(negedge clk);
        check("gnt_drop_status", status(), 4'b0010);

        // Contention: seal request mid CPU byte
        pulse_cpu_init();
        for (int i = 0; i < 4; i++) send_cpu(s9[i]);
        seal_req = 1;
        @(negedge clk);
        check("gnt_held_off_mid_byte", {31'h0, seal_gnt}, 0);
        grant();
        expect_item("cpu_1234_during_seal", 0, ~m_cpu);
        send_seal(8'h61, 1);
        expect_item("seal_a_value", 1, 32'hE8B7BE43);
        expect_item("cpu_isolated", 0, ~m_cpu);
        sync();
        release_seal();
        for (int i = 4; i < 9; i++) send_cpu(s9[i]);
        expect_item("cpu_resumed_value", 0, 32'hCBF43926);
        expect_item("seal_isolated", 1, 32'hE8B7BE43);
        sync();

        // Same-cycle seal_req and cpu_valid at IDLE
        pulse_cpu_init();
        seal_req = 1; cpu_valid = 1; cpu_data = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("same_cycle_status", status(), 4'b1101);
        end
        seal_req = 0;
        send_cpu(8'h00);
        expect_item("same_cycle_cpu_once", 0, 32'hD202EF8D);
        sync();

        // cpu_init during a CPU byte
        pulse_cpu_init();
        send_cpu(8'h31);
        pulse_cpu_init();
        expect_item("init_mid_byte", 0, 32'h00000000);
        sync();
        send_cpu(8'h00);
        expect_item("byte_after_init", 0, 32'hD202EF8D);
        sync();

        // Reset during SEAL_RUN
        grant();
        send_seal(8'h55, 1);
        seal_req = 0;
        #2 rst_n = 0;
        #1;
        check("rst_async_status", status(), 4'b0010);
        check("rst_async_cpu_crc", cpu_crc, 0);
        check("rst_async_seal_crc", seal_crc, 0);
        m_cpu = 32'hFFFFFFFF; m_seal = 32'hFFFFFFFF;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        for (int i = 0; i < 9; i++) send_cpu(s9[i]);
        expect_item("post_reset_cpu", 0, 32'hCBF43926);
        sync();

        // Randomized mix against the reference model
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    send_cpu(8'($urandom));
                    expect_item("rnd_cpu_byte", 0, ~m_cpu);
                end
                1: begin
                    pulse_cpu_init();
                    expect_item("rnd_cpu_init", 0, ~m_cpu);
                end
                2: begin
                    grant();
                    send_seal(8'($urandom), 1'($urandom));
                    for (int k = $urandom_range(0, 2); k > 0; k--) send_seal(8'($urandom), 0);
                    expect_item("rnd_seal", 1, ~m_seal);
                    expect_item("rnd_cpu_hold", 0, ~m_cpu);
                    sync();
                    release_seal();
                end
                default: begin
                    send_cpu(8'($urandom));
                    grant();
                    expect_item("rnd_cont_cpu", 0, ~m_cpu);
                    send_seal(8'($urandom), 1'($urandom));
                    expect_item("rnd_cont_seal", 1, ~m_seal);
                    sync();
                    release_seal();
                end
            endcase
            sync();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/crc_arb_engine.md
Name: crc_arb_engine

Overview:
Shared CRC-32 engine (IEEE 802.3, reflected) with two requesters: the seal sequencer (priority) and the CPU CRC MMIO port.
- One bit-serial datapath, time-shared between the two requesters.
- Each requester has its own 32-bit accumulator, so a CPU CRC survives an intervening seal.
- Sits between the seal FSM / CPU peripheral decode and the single CRC step logic; it is the stage whose correctness the CRC-arbitration firmware test exercises.

Parameters:
BITS_PER_CYCLE, 2, bits folded per clock; legal values 1, 2, 4, 8; byte latency = 8/BITS_PER_CYCLE cycles.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cpu_init  in  1  one-cycle pulse: reset CPU accumulator to 0xFFFFFFFF
cpu_valid  in  1  CPU byte present
cpu_data  in  8  CPU byte
cpu_ready  out  1  CPU byte accepted when cpu_valid & cpu_ready
cpu_busy  out  1  CPU byte in flight, or seal owns the engine
cpu_crc  out  32  ~CPU accumulator (final CRC)
seal_req  in  1  level; seal wants the engine
seal_gnt  out  1  seal owns the engine
seal_init  in  1  pulse, honoured only while seal_gnt: reset seal accumulator
seal_valid  in  1  seal byte present, ignored unless seal_gnt
seal_data  in  8  seal byte
seal_ready  out  1  seal byte accepted when seal_valid & seal_ready
seal_crc  out  32  ~seal accumulator

Behaviour:
- Reset (async, immediate):
  - state IDLE; both accumulators 0xFFFFFFFF, so cpu_crc = seal_crc = 0x00000000.
  - seal_gnt = 0, cpu_busy = 0, cpu_ready = 1, seal_ready = 0.
  - Bit counter 0; pending-init flag 0.
- FSM states:
  - IDLE: engine free.
  - CPU_RUN: CPU byte shifting.
  - SEAL_OWN: seal granted, no byte in flight.
  - SEAL_RUN: seal byte shifting.
- Transitions:
  - IDLE → SEAL_OWN: seal_req = 1. seal_gnt rises the next cycle. The seal wins over a same-cycle cpu_valid; cpu_ready is 0 in any cycle where seal_req = 1.
  - IDLE → CPU_RUN: cpu_valid & cpu_ready with seal_req = 0.
  - CPU_RUN → IDLE: after 8/BPC cycles. If seal_req is high at completion, go straight to SEAL_OWN; the CPU byte is never aborted.
  - SEAL_OWN → SEAL_RUN: seal_valid & seal_ready.
  - SEAL_RUN → SEAL_OWN: after 8/BPC cycles.
  - SEAL_OWN → IDLE: seal_req = 0. seal_gnt falls the same cycle the state leaves.
  - seal_req dropping during SEAL_RUN: the byte completes into the seal accumulator, then the engine returns to IDLE.
- Handshake outputs:
  - cpu_ready = (state == IDLE) & ~seal_req.
  - seal_ready = (state == SEAL_OWN).
  - cpu_busy = (state != IDLE).
- Datapath:
  - Shift register loaded with the byte at accept.
  - Each cycle, fold BITS_PER_CYCLE LSB-first bits into the owner's accumulator (poly 0xEDB88320).
  - The accumulator reaches its final value on the last fold cycle. The new crc output is visible on the cycle after the 8/BPC-th edge, together with ready re-asserting.
- Init handling:
  - cpu_init during CPU_RUN: set the pending flag; apply it at byte completion, overriding that byte's result.
  - cpu_init at any other time: applied next edge.
  - cpu_init during seal ownership: applies to the CPU accumulator immediately (the CPU accumulator is idle then).
  - seal_init & seal_valid in the same cycle: init first, then the byte is folded into 0xFFFFFFFF.
  - seal_init while not granted: ignored.
- Accumulator isolation: the non-owner accumulator holds its value unchanged.

Decomposition:
- Package crc_pkg holds:
  - CRC32_POLY = 0xEDB88320, CRC32_INIT = 0xFFFFFFFF, CRC32_XOROUT = 0xFFFFFFFF.
  - The state enum {IDLE, CPU_RUN, SEAL_OWN, SEAL_RUN}.
  - Owner encoding.
- Sub-module crc32_step: combinational; inputs crc[31:0] and BITS_PER_CYCLE data bits; output next crc. Instantiated once, with its input muxed by owner.

Test Plan:
- CPU alone, bytes "123456789" after cpu_init → cpu_crc = 0xCBF43926; each byte takes 4 cycles at default BPC; cpu_busy = 0 at end.
- Seal alone: seal_req, gnt next cycle, seal_init, four 0x00 bytes → seal_crc = 0x2144DF1C.
  - Drop seal_req → seal_gnt = 0 next cycle, cpu_ready = 1.
- Contention:
  - CPU feeds "1234"; seal_req rises mid-byte → seal_gnt only after that byte completes.
  - Seal hashes "a" → seal_crc = 0xE8B7BE43; seal releases.
  - CPU feeds "56789" → cpu_crc = 0xCBF43926 (context preserved).
- Same-cycle seal_req and cpu_valid at IDLE → seal_gnt = 1, the CPU byte is not accepted until release; cpu_busy = 1 throughout.
- cpu_init pulsed during a CPU byte → after completion cpu_crc = 0x00000000; then byte 0x00 → cpu_crc = 0xD202EF8D.
- rst_n asserted mid SEAL_RUN → same-timestep seal_gnt = 0, both crc outputs 0x00000000, cpu_ready = 1; post-reset "123456789" on CPU → 0xCBF43926.
